// File: rtl/series_gen.sv
// Serial pattern transmitter: sends an up-to-W-bit pattern MSB-first on x, with repeats and idle gaps.
// Moore outputs decoded from registered state; start is only taken in IDLE, abort/rst cancel at the next edge.
module series_gen #(
   parameter int W     = 5,
   parameter int LEN_W = 3,
   parameter int RPT_W = 4,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     pat_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic [RPT_W-1:0] rpt_in,
   input  logic [GAP_W-1:0] gap_in,
   input  logic             abort,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             frame_end,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t           state, state_n;
   logic [W-1:0]     pat, pat_n, shreg, shreg_n;
   logic [LEN_W-1:0] len, len_n, idx, idx_n;
   logic [RPT_W-1:0] rpt, rpt_n;
   logic [GAP_W-1:0] gap, gap_n, gcnt, gcnt_n;
   logic             done_r, done_n;
   logic [LEN_W-1:0] len_eff;
   logic [W-1:0]     pat_al;

   // Pattern is stored left-aligned so the next bit to send is always shreg[W-1].
   always_comb begin
      len_eff = len_in;
      if (len_in == '0 || len_in > LEN_W'(W))
         len_eff = LEN_W'(W);
      pat_al = pat_in << (LEN_W'(W) - len_eff);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         pat    <= '0;
         shreg  <= '0;
         len    <= '0;
         idx    <= '0;
         rpt    <= '0;
         gap    <= '0;
         gcnt   <= '0;
         done_r <= 1'b0;
      end else begin
         state  <= state_n;
         pat    <= pat_n;
         shreg  <= shreg_n;
         len    <= len_n;
         idx    <= idx_n;
         rpt    <= rpt_n;
         gap    <= gap_n;
         gcnt   <= gcnt_n;
         done_r <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      pat_n   = pat;
      shreg_n = shreg;
      len_n   = len;
      idx_n   = idx;
      rpt_n   = rpt;
      gap_n   = gap;
      gcnt_n  = gcnt;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_n = SHIFT;
               pat_n   = pat_al;
               shreg_n = pat_al;
               len_n   = len_eff;
               idx_n   = len_eff - LEN_W'(1);
               rpt_n   = rpt_in;
               gap_n   = gap_in;
               gcnt_n  = '0;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_n = IDLE;
            end else if (idx != '0) begin
               idx_n   = idx - LEN_W'(1);
               shreg_n = shreg << 1;
            end else if (rpt != '0) begin
               // Counting down from rpt_in means the max setting never wraps.
               rpt_n   = rpt - RPT_W'(1);
               shreg_n = pat;
               idx_n   = len - LEN_W'(1);
               if (gap != '0) begin
                  state_n = GAP;
                  gcnt_n  = gap - GAP_W'(1);
               end
            end else begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         GAP: begin
            if (abort)
               state_n = IDLE;
            else if (gcnt == '0)
               state_n = SHIFT;
            else
               gcnt_n = gcnt - GAP_W'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   assign x         = (state == SHIFT) & shreg[W-1];
   assign x_valid   = (state == SHIFT);
   assign busy      = (state != IDLE);
   assign frame_end = (state == SHIFT) && (idx == '0);
   assign done      = done_r;

endmodule

// File: tb/tb_series_gen.sv
// Bench for series_gen: directed scenarios then random traffic, compared against a frame-list reference model.
module tb_series_gen;
   localparam int W     = 5;
   localparam int LEN_W = 3;
   localparam int RPT_W = 4;
   localparam int GAP_W = 4;

   logic             clk = 1'b0;
   logic             rst, start, abort;
   logic [W-1:0]     pat_in;
   logic [LEN_W-1:0] len_in;
   logic [RPT_W-1:0] rpt_in;
   logic [GAP_W-1:0] gap_in;
   logic             x, x_valid, busy, frame_end, done;

   int n_cmp = 0;
   int n_bad = 0;
   // Expected {x, x_valid, busy, frame_end, done} per cycle, front = current cycle.
   logic [4:0] exp_q[$];

   series_gen #(.W(W), .LEN_W(LEN_W), .RPT_W(RPT_W), .GAP_W(GAP_W)) dut (
      .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .len_in(len_in),
      .rpt_in(rpt_in), .gap_in(gap_in), .abort(abort), .x(x), .x_valid(x_valid),
      .busy(busy), .frame_end(frame_end), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (x,x_valid,busy,frame_end,done)", tag, got[4:0], exp[4:0]);
      end
   endtask

   // Whole transmission as a list of cycles: frames of L bits, gaps between them, then a done cycle.
   task automatic load_txn();
      int L;
      L = (len_in == 0 || int'(len_in) > W) ? W : int'(len_in);
      exp_q.delete();
      for (int f = 0; f <= int'(rpt_in); f++) begin
         for (int k = 0; k < L; k++)
            exp_q.push_back({pat_in[L-1-k], 1'b1, 1'b1, (k == L-1), 1'b0});
         if (f < int'(rpt_in))
            for (int g = 0; g < int'(gap_in); g++)
               exp_q.push_back(5'b00100);
      end
      exp_q.push_back(5'b00001);
   endtask

   task automatic step(input logic s, input logic a, input logic r, input string tag);
      logic [4:0] cur;
      cur = (exp_q.size() > 0) ? exp_q[0] : 5'b00000;
      check(tag, {27'd0, x, x_valid, busy, frame_end, done}, {27'd0, cur});
      start = s;
      abort = a;
      rst   = r;
      @(posedge clk);
      if (r)
         exp_q.delete();
      else if (cur[2] && a)
         exp_q.delete();
      else if (!cur[2] && s && !a)
         load_txn();
      else if (exp_q.size() > 0)
         void'(exp_q.pop_front());
      @(negedge clk);
   endtask

   task automatic idle(input int n, input string tag);
      repeat (n) step(1'b0, 1'b0, 1'b0, tag);
   endtask

   task automatic cfg(input logic [W-1:0] p, input logic [LEN_W-1:0] l,
                      input logic [RPT_W-1:0] r, input logic [GAP_W-1:0] g);
      pat_in = p;
      len_in = l;
      rpt_in = r;
      gap_in = g;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      cfg('0, '0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(1'b0, 1'b0, 1'b1, "reset");
      step(1'b0, 1'b0, 1'b0, "reset");

      cfg(5'b10101, 3'd5, 4'd0, 4'd0);
      step(1'b1, 1'b0, 1'b0, "s1_start");
      idle(8, "s1");

      cfg(5'b00110, 3'd3, 4'd1, 4'd2);
      step(1'b1, 1'b0, 1'b0, "s2_start");
      idle(11, "s2");

      cfg(5'b10101, 3'd5, 4'd1, 4'd0);
      step(1'b1, 1'b0, 1'b0, "s3_start");
      idle(12, "s3");

      cfg(5'b11001, 3'd0, 4'd0, 4'd0);
      step(1'b1, 1'b0, 1'b0, "s4_start");
      step(1'b0, 1'b0, 1'b0, "s4");
      step(1'b1, 1'b0, 1'b0, "s4_busy_start");
      idle(3, "s4");
      step(1'b1, 1'b0, 1'b0, "s4_done_start");
      idle(7, "s4_restart");

      cfg(5'b10101, 3'd5, 4'd0, 4'd0);
      step(1'b1, 1'b0, 1'b0, "s5_start");
      idle(2, "s5");
      step(1'b0, 1'b1, 1'b0, "s5_abort");
      idle(4, "s5_after_abort");
      step(1'b1, 1'b1, 1'b0, "s5_abort_start_idle");
      idle(2, "s5_idle");
      step(1'b1, 1'b0, 1'b0, "s5_start2");
      idle(2, "s5");
      step(1'b0, 1'b0, 1'b1, "s5_rst");
      idle(3, "s5_after_rst");
      step(1'b1, 1'b0, 1'b0, "s5_start3");
      idle(8, "s5_post_rst");

      cfg(5'b00001, 3'd1, 4'd15, 4'd15);
      step(1'b1, 1'b0, 1'b0, "s6_start");
      idle(250, "s6");

      for (int i = 0; i < 3000; i++) begin
         logic s, a, r;
         if ($urandom_range(0, 3) == 0)
            cfg(W'($urandom), LEN_W'($urandom), RPT_W'($urandom_range(0, 3)), GAP_W'($urandom_range(0, 4)));
         s = ($urandom_range(0, 3) == 0);
         a = ($urandom_range(0, 39) == 0);
         r = ($urandom_range(0, 149) == 0);
         step(s, a, r, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
